// File: rtl/ws2812_pkg.sv
// ----------------------------------------------------------------------------
// ws2812_pkg
// Shared definitions for the WS2812 chain driver: FSM state encoding, default
// pulse timing (in clk cycles), pixel word width and the address-width helper.
// ----------------------------------------------------------------------------
package ws2812_pkg;

   localparam int PIX_W      = 24;     // one GRB word, sent MSB first
   localparam int DEF_L_TIME = 80;     // long phase
   localparam int DEF_S_TIME = 40;     // short phase
   localparam int DEF_R_TIME = 5000;   // latch (strip reset) low time
   localparam int DEF_CNT_W  = 16;

   // Encoding is visible on o_state_dbg, so keep it stable.
   typedef enum logic [2:0] {
      ST_BOOT_WAIT = 3'd0,
      ST_IDLE      = 3'd1,
      ST_FETCH     = 3'd2,
      ST_LOAD      = 3'd3,
      ST_HIGH      = 3'd4,
      ST_LOW       = 3'd5,
      ST_LATCH     = 3'd6
   } state_e;

   // Pixel address width; a single-LED chain still gets a 1-bit address.
   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ws2812_phase_timer.sv
// ----------------------------------------------------------------------------
// ws2812_phase_timer
// Loadable down-counter shared by every timed phase (BOOT_WAIT, HIGH, LOW,
// LATCH). Loading N-1 gives a phase of exactly N cycles: o_done is high in the
// last cycle (count == 0). The counter stops at zero, it never wraps.
//
// Ports
//   i_clk       clock
//   i_rstn      async active-low reset, loads RST_VAL
//   i_load      load i_load_val this edge (takes priority over counting)
//   i_load_val  phase length - 1
//   o_done      count is zero (final cycle of the phase)
// ----------------------------------------------------------------------------
module ws2812_phase_timer #(
   parameter int               CNT_W   = 16,
   parameter logic [CNT_W-1:0] RST_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   output logic             o_done
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_cnt <= RST_VAL;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign o_done = (r_cnt == '0);

endmodule

// File: rtl/ws2812_chain_driver.sv
// ----------------------------------------------------------------------------
// ws2812_chain_driver
// Streams NUM_LEDS 24-bit pixels from an external pixel store onto one WS2812
// data pin (long/short pulse encoding, MSB first), then holds the pin low for
// the latch period. After reset the pin is held low for one latch period
// before the first frame can start, so a strip interrupted mid-frame latches.
//
// Ports
//   i_clk             clock, all logic on the rising edge
//   i_rstn            async active-low reset
//   i_start           one-shot frame request, only honoured in IDLE
//   i_cont            continuous refresh enable
//   o_pix_rd          one-cycle pixel read strobe
//   o_pix_addr        pixel index, valid with o_pix_rd, holds between strobes
//   i_pix_data        pixel word, valid the cycle after o_pix_rd
//   o_led_stripe_pin  encoded serial output (registered)
//   o_busy            high whenever not IDLE
//   o_frame_done      one-cycle pulse in the final latch cycle
//   o_state_dbg       current FSM state
// ----------------------------------------------------------------------------
module ws2812_chain_driver
   import ws2812_pkg::*;
#(
   parameter int NUM_LEDS = 8,
   parameter int L_TIME   = DEF_L_TIME,
   parameter int S_TIME   = DEF_S_TIME,
   parameter int R_TIME   = DEF_R_TIME,
   parameter int CNT_W    = DEF_CNT_W,
   parameter int ADDR_W   = addr_w(NUM_LEDS)
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic              i_start,
   input  logic              i_cont,
   output logic              o_pix_rd,
   output logic [ADDR_W-1:0] o_pix_addr,
   input  logic [PIX_W-1:0]  i_pix_data,
   output logic              o_led_stripe_pin,
   output logic              o_busy,
   output logic              o_frame_done,
   output logic [2:0]        o_state_dbg
);

   localparam logic [CNT_W-1:0]  L_LEN    = CNT_W'(L_TIME - 1);
   localparam logic [CNT_W-1:0]  S_LEN    = CNT_W'(S_TIME - 1);
   localparam logic [CNT_W-1:0]  R_LEN    = CNT_W'(R_TIME - 1);
   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_LEDS - 1);
   localparam logic [4:0]        TOP_BIT  = 5'(PIX_W - 1);

   state_e            r_state, w_state_nxt;

   logic              w_tmr_done;
   logic              w_tmr_load;
   logic [CNT_W-1:0]  w_tmr_val;

   logic              w_issue_rd;
   logic [ADDR_W-1:0] w_issue_addr;
   logic              w_last_bit;
   logic              w_last_pix;

   logic [PIX_W-1:0]  r_shift;      // current pixel, bit being sent is [PIX_W-1]
   logic [PIX_W-1:0]  r_prefetch;   // next pixel, fetched during bit 0 of this one
   logic [4:0]        r_bit_idx;
   logic [ADDR_W-1:0] r_pix_idx;
   logic              r_pix_rd;
   logic              r_rd_d;
   logic [ADDR_W-1:0] r_pix_addr;
   logic              r_pin;

   function automatic logic [CNT_W-1:0] high_len(input logic b);
      return b ? L_LEN : S_LEN;
   endfunction

   function automatic logic [CNT_W-1:0] low_len(input logic b);
      return b ? S_LEN : L_LEN;
   endfunction

   assign w_last_bit = (r_bit_idx == 5'd0);
   assign w_last_pix = (r_pix_idx == LAST_PIX);

   ws2812_phase_timer #(
      .CNT_W   (CNT_W),
      .RST_VAL (R_LEN)           // BOOT_WAIT runs straight out of reset
   ) u_timer (
      .i_clk      (i_clk),
      .i_rstn     (i_rstn),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .o_done     (w_tmr_done)
   );

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) r_state <= ST_BOOT_WAIT;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_tmr_load   = 1'b0;
      w_tmr_val    = '0;
      w_issue_rd   = 1'b0;
      w_issue_addr = '0;
      o_frame_done = 1'b0;
      case (r_state)
         ST_BOOT_WAIT: if (w_tmr_done) w_state_nxt = ST_IDLE;
         ST_IDLE: begin
            if (i_start || i_cont) begin
               w_state_nxt = ST_FETCH;
               w_issue_rd  = 1'b1;
            end
         end
         ST_FETCH: w_state_nxt = ST_LOAD;
         ST_LOAD: begin
            w_state_nxt = ST_HIGH;
            w_tmr_load  = 1'b1;
            w_tmr_val   = high_len(i_pix_data[PIX_W-1]);
         end
         ST_HIGH: begin
            if (w_tmr_done) begin
               w_state_nxt = ST_LOW;
               w_tmr_load  = 1'b1;
               w_tmr_val   = low_len(r_shift[PIX_W-1]);
            end
         end
         ST_LOW: begin
            if (w_tmr_done) begin
               if (!w_last_bit) begin
                  // Next bit is r_shift[PIX_W-2]; it becomes the MSB after the shift.
                  w_state_nxt = ST_HIGH;
                  w_tmr_load  = 1'b1;
                  w_tmr_val   = high_len(r_shift[PIX_W-2]);
                  // Strobe lands in the first HIGH cycle of bit 0 so the next
                  // word is in r_prefetch long before the pixel boundary.
                  if (r_bit_idx == 5'd1 && !w_last_pix) begin
                     w_issue_rd   = 1'b1;
                     w_issue_addr = r_pix_idx + ADDR_W'(1);
                  end
               end else if (!w_last_pix) begin
                  w_state_nxt = ST_HIGH;
                  w_tmr_load  = 1'b1;
                  w_tmr_val   = high_len(r_prefetch[PIX_W-1]);
               end else begin
                  w_state_nxt = ST_LATCH;
                  w_tmr_load  = 1'b1;
                  w_tmr_val   = R_LEN;
               end
            end
         end
         ST_LATCH: begin
            if (w_tmr_done) begin
               o_frame_done = 1'b1;
               if (i_cont) begin
                  w_state_nxt = ST_FETCH;
                  w_issue_rd  = 1'b1;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_pix_rd   <= 1'b0;
         r_pix_addr <= '0;
         r_rd_d     <= 1'b0;
         r_pin      <= 1'b0;
         r_shift    <= '0;
         r_prefetch <= '0;
         r_bit_idx  <= '0;
         r_pix_idx  <= '0;
      end else begin
         r_pix_rd <= w_issue_rd;
         if (w_issue_rd) r_pix_addr <= w_issue_addr;
         r_rd_d <= r_pix_rd;
         // Registered pin: glitch-free pad drive, lags the state by one cycle.
         r_pin  <= (r_state == ST_HIGH);
         // Data of a prefetch strobe arrives in the second HIGH cycle of bit 0
         // (HIGH is at least 2 cycles long); the FETCH read is taken by LOAD.
         if (r_rd_d && r_state == ST_HIGH) r_prefetch <= i_pix_data;
         case (r_state)
            ST_LOAD: begin
               r_shift   <= i_pix_data;
               r_bit_idx <= TOP_BIT;
               r_pix_idx <= '0;
            end
            ST_LOW: begin
               if (w_tmr_done) begin
                  if (!w_last_bit) begin
                     r_shift   <= r_shift << 1;
                     r_bit_idx <= r_bit_idx - 5'd1;
                  end else if (!w_last_pix) begin
                     r_shift   <= r_prefetch;
                     r_bit_idx <= TOP_BIT;
                     r_pix_idx <= r_pix_idx + ADDR_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign o_pix_rd         = r_pix_rd;
   assign o_pix_addr       = r_pix_addr;
   assign o_led_stripe_pin = r_pin;
   assign o_busy           = (r_state != ST_IDLE);
   assign o_state_dbg      = r_state;

endmodule

// File: tb/tb_ws2812_chain_driver.sv
// ----------------------------------------------------------------------------
// tb_ws2812_chain_driver
// Two instances: a 3-LED chain (L=8, S=4, R=50) and a 1-LED chain with the same
// timing. A negedge monitor turns the selected instance's pin into high/low
// run lengths and logs read strobes and frame_done pulses; directed frames
// from a vector table are then checked bit by bit against the pixel words.
// ----------------------------------------------------------------------------
module tb_ws2812_chain_driver;

   localparam int L = 8;
   localparam int S = 4;
   localparam int R = 50;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start0 = 1'b0, cont0 = 1'b0, start1 = 1'b0, cont1 = 1'b0;
   logic        rd0, rd1, pin0, pin1, busy0, busy1, done0, done1;
   logic [1:0]  addr0;
   logic [0:0]  addr1;
   logic [2:0]  st0, st1;
   logic [23:0] pd0 = '0, pd1 = '0;
   logic [23:0] mem0 [3];
   logic [23:0] mem1 = '0;
   logic        sel = 1'b0;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   ws2812_chain_driver #(.NUM_LEDS(3), .L_TIME(L), .S_TIME(S), .R_TIME(R), .CNT_W(16)) dut0 (
      .i_clk(clk), .i_rstn(rstn), .i_start(start0), .i_cont(cont0),
      .o_pix_rd(rd0), .o_pix_addr(addr0), .i_pix_data(pd0),
      .o_led_stripe_pin(pin0), .o_busy(busy0), .o_frame_done(done0), .o_state_dbg(st0));

   ws2812_chain_driver #(.NUM_LEDS(1), .L_TIME(L), .S_TIME(S), .R_TIME(R), .CNT_W(16)) dut1 (
      .i_clk(clk), .i_rstn(rstn), .i_start(start1), .i_cont(cont1),
      .o_pix_rd(rd1), .o_pix_addr(addr1), .i_pix_data(pd1),
      .o_led_stripe_pin(pin1), .o_busy(busy1), .o_frame_done(done1), .o_state_dbg(st1));

   // Pixel store: registered read, data valid the cycle after the strobe.
   always @(posedge clk) begin
      if (rd0) pd0 <= mem0[addr0];
      if (rd1) pd1 <= mem1;
   end

   // ---------------------------------------------------------------- monitor
   wire       m_pin  = sel ? pin1  : pin0;
   wire       m_rd   = sel ? rd1   : rd0;
   wire       m_done = sel ? done1 : done0;
   wire [1:0] m_addr = sel ? {1'b0, addr1} : addr0;

   int hi_q[$], lo_q[$], rise_q[$], addr_q[$];
   int done_cnt = 0, done_t = 0, cyc = 0, run = 0;
   logic prev = 1'b0;

   always @(negedge clk) begin
      if (m_pin) begin
         if (!prev) begin
            lo_q.push_back(run);
            rise_q.push_back(cyc);
            run = 0;
         end
         run++;
      end else begin
         if (prev) begin
            hi_q.push_back(run);
            run = 0;
         end
         run++;
      end
      prev = m_pin;
      if (m_rd) addr_q.push_back(int'(m_addr));
      if (m_done) begin
         done_cnt++;
         done_t = cyc;
      end
      cyc++;
   end

   // ---------------------------------------------------------------- helpers
   task automatic chk(input string nm, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      if (sel) start1 = 1'b1; else start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   // Counts negedges (from the release instant) during which busy stays high.
   task automatic release_and_boot(input string nm);
      int n;
      @(negedge clk);
      rstn = 1'b1;
      n = 0;
      while (busy0 && n < 500) begin
         n++;
         @(negedge clk);
      end
      chk({nm, "_boot_busy_cycles"}, n, R);
   endtask

   task automatic run_frame(input string nm, input logic [2:0][23:0] px,
                            input int n, input int exp_longs);
      int hb, lb, rb, ab, db, k, longs, idx;
      logic b;
      for (int i = 0; i < 3; i++) mem0[i] = px[i];
      mem1 = px[0];
      hb = hi_q.size(); lb = lo_q.size(); rb = rise_q.size();
      ab = addr_q.size(); db = done_cnt;
      pulse_start();
      k = 0;
      while (done_cnt == db && k < 5000) begin
         @(negedge clk);
         k++;
      end
      chk({nm, "_done_seen"}, (k < 5000), 1);
      repeat (10) @(negedge clk);
      chk({nm, "_rd_count"}, addr_q.size() - ab, n);
      for (int i = 0; i < n; i++)
         if (addr_q.size() > ab + i) chk($sformatf("%s_addr%0d", nm, i), addr_q[ab + i], i);
      chk({nm, "_bit_count"}, hi_q.size() - hb, 24 * n);
      chk({nm, "_rise_count"}, rise_q.size() - rb, 24 * n);
      if (hi_q.size() - hb == 24 * n) begin
         longs = 0;
         for (int p = 0; p < n; p++) begin
            for (int j = 0; j < 24; j++) begin
               idx = p * 24 + j;
               b   = px[p][23 - j];
               chk($sformatf("%s_hi_bit%0d", nm, idx), hi_q[hb + idx], b ? L : S);
               // lo_q[lb] is the idle time before the frame's first rise.
               if (idx < 24 * n - 1)
                  chk($sformatf("%s_lo_bit%0d", nm, idx), lo_q[lb + 1 + idx], b ? S : L);
               if (hi_q[hb + idx] == L) longs++;
            end
         end
         chk({nm, "_long_pulses"}, longs, exp_longs);
      end
      // Pin is registered, so its first rise trails the HIGH state by a cycle
      // while frame_done is in the last LATCH cycle itself.
      if (rise_q.size() > rb)
         chk({nm, "_rise_to_done"}, done_t - rise_q[rb], n * 24 * (L + S) + R - 2);
      chk({nm, "_done_pulses"}, done_cnt - db, 1);
      chk({nm, "_busy_after"}, sel ? busy1 : busy0, 0);
      chk({nm, "_pin_after"}, sel ? pin1 : pin0, 0);
   endtask

   // ---------------------------------------------------------------- vectors
   typedef struct {
      logic [2:0][23:0] px;        // px[0] is pixel 0
      int               exp_longs; // hand count of '1' bits in the frame
   } vec_t;

   vec_t vecs[4];

   initial begin
      int k, ab, db, lb2, rb;
      logic [2:0][23:0] pm;

      vecs[0].px = {24'h800001, 24'h000000, 24'hFF0000}; vecs[0].exp_longs = 10;
      vecs[1].px = {24'hFFFFFF, 24'h555555, 24'hAAAAAA}; vecs[1].exp_longs = 48;
      vecs[2].px = {24'h000000, 24'h000000, 24'h000000}; vecs[2].exp_longs = 0;
      vecs[3].px = {24'h0F0F0F, 24'hFEDCBA, 24'h123456}; vecs[3].exp_longs = 38;
      for (int i = 0; i < 3; i++) mem0[i] = '0;

      // ---- reset state
      #2;
      chk("rst_pin", pin0, 0);
      chk("rst_busy", busy0, 1);
      chk("rst_pix_rd", rd0, 0);
      chk("rst_pix_addr", addr0, 0);
      chk("rst_frame_done", done0, 0);
      chk("rst_state", st0, 0);
      release_and_boot("por");
      chk("por_no_frame_done", done_cnt, 0);
      chk("por_state_idle", st0, 1);
      chk("por_busy1", busy1, 0);

      // ---- table-driven single-shot frames
      for (int v = 0; v < 4; v++) run_frame($sformatf("vec%0d", v), vecs[v].px, 3, vecs[v].exp_longs);

      // ---- start while busy and on the frame_done cycle is dropped
      for (int i = 0; i < 3; i++) mem0[i] = vecs[0].px[i];
      ab = addr_q.size(); db = done_cnt;
      pulse_start();
      repeat (300) @(negedge clk);
      pulse_start();
      k = 0;
      while (!done0 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("ign_done_seen", (k < 3000), 1);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (100) @(negedge clk);
      chk("ign_rd_count", addr_q.size() - ab, 3);
      chk("ign_done_pulses", done_cnt - db, 1);
      chk("ign_busy", busy0, 0);

      // ---- continuous mode: two frames, cont dropped during the second
      ab = addr_q.size(); db = done_cnt;
      @(negedge clk);
      cont0 = 1'b1;
      k = 0;
      while (done_cnt == db && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("cont_first_done", (k < 3000), 1);
      lb2 = lo_q.size();
      repeat (100) @(negedge clk);
      cont0 = 1'b0;
      k = 0;
      while (done_cnt < db + 2 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("cont_second_done", (k < 3000), 1);
      repeat (100) @(negedge clk);
      chk("cont_done_pulses", done_cnt - db, 2);
      chk("cont_rd_count", addr_q.size() - ab, 6);
      if (addr_q.size() >= ab + 4) chk("cont_f2_addr0", addr_q[ab + 3], 0);
      // Last bit of pixel 2 is '1': its short low plus latch, FETCH and LOAD.
      if (lo_q.size() > lb2) chk("cont_gap", lo_q[lb2], S + R + 2);
      chk("cont_busy", busy0, 0);
      chk("cont_state_idle", st0, 1);

      // ---- reset in the middle of a HIGH phase of pixel 1
      pm = {24'h000000, 24'hFFFFFF, 24'hFF0000};
      for (int i = 0; i < 3; i++) mem0[i] = pm[i];
      rb = rise_q.size();
      pulse_start();
      k = 0;
      while (rise_q.size() < rb + 26 && k < 2000) begin
         @(negedge clk);
         k++;
      end
      chk("mid_rise_seen", (k < 2000), 1);
      repeat (2) @(negedge clk);
      chk("mid_pin_high", pin0, 1);
      #2 rstn = 1'b0;
      #1;
      chk("mid_rst_pin", pin0, 0);
      chk("mid_rst_busy", busy0, 1);
      chk("mid_rst_state", st0, 0);
      db = done_cnt;
      repeat (3) @(negedge clk);
      release_and_boot("mid");
      chk("mid_no_frame_done", done_cnt - db, 0);
      run_frame("post_rst", vecs[0].px, 3, vecs[0].exp_longs);

      // ---- single-LED chain
      sel = 1'b1;
      repeat (3) @(negedge clk);
      pm = {24'h000000, 24'h000000, 24'hA50F3C};
      run_frame("one_led", pm, 1, 12);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
